fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. Owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and returns responses to decode through a one-entry output register with valid/ready. Handles redirects from execute (branch/jump) by flushing the output register and discarding any in-flight memory response. Sits between the execute-stage redirect logic, instruction memory and decode.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_ctrl.sv | 60 ++++++
 tb/tb_fetch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_e;
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode handshakes around fetch_ctrl
interface fetch_if;
    import fetch_pkg::*;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, single-outstanding imem requests and a one-entry decode register
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    fetch_state_e    state, state_nx;
    logic [XLEN-1:0] pc, req_pc, if_pc_q, if_instr_q;
    logic            if_valid_q;
    logic            buf_free, req_valid, req_fire, rsp_keep, redir, rsp;

    assign redir = bus.redirect_valid;
    assign rsp = bus.imem_rsp_valid;
    assign buf_free = !if_valid_q || bus.if_ready;
    // Issue only into an empty (or draining) output register so a response never finds it full
    assign req_valid = (state == REQ) && buf_free && !redir && rst_n;
    assign req_fire = req_valid && bus.imem_req_ready;
    assign rsp_keep = (state == WAIT) && rsp && !redir;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr = pc;
    assign bus.if_valid = if_valid_q;
    assign bus.if_pc = if_pc_q;
    assign bus.if_instr = if_instr_q;

    always_comb begin
        state_nx = state;
        state_nx = (state == REQ) ? (req_fire ? WAIT : REQ) :
                   rsp ? REQ :
                   (state == WAIT && !redir) ? WAIT : DROP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= REQ;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            req_pc <= '0;
            if_valid_q <= 1'b0;
            if_pc_q <= '0;
            if_instr_q <= '0;
        end else begin
            if (redir) pc <= align_pc(bus.redirect_pc);
            else if (req_fire) pc <= pc + PC_STEP;
            if (req_fire) req_pc <= pc;
            if (rsp_keep) begin
                if_pc_q <= req_pc;
                if_instr_q <= bus.imem_rsp_data;
            end
            if_valid_q <= redir ? 1'b0 : rsp_keep ? 1'b1 : (if_valid_q && !bus.if_ready);
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven and directed checks of fetch_ctrl with a request/response scoreboard
module tb_fetch_ctrl;
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
    } vec_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fetch_if bus();
    fetch_ctrl #(.RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cnt = 0;
    logic pend = 1'b0;
    logic inject = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_req[$];
    out_t exp_out[$];
    vec_t vt[7];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected transaction, none expected", name);
    endtask

    // Drive this cycle's memory response, then let combinational outputs settle
    task automatic pre();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        if (inject) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = 32'hDEAD_BEEF;
            inject = 1'b0;
        end else if (pend) begin
            if (cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = instr_of(pend_addr);
                pend = 1'b0;
            end else cnt--;
        end
        #1;
    endtask

    task automatic post();
        out_t o;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (exp_req.size() == 0) miss("sb_req");
            else check("sb_req_addr", bus.imem_req_addr, exp_req.pop_front());
            pend = 1'b1;
            pend_addr = bus.imem_req_addr;
            cnt = lat - 1;
        end
        if (bus.if_valid && bus.if_ready) begin
            if (exp_out.size() == 0) miss("sb_out");
            else begin
                o = exp_out.pop_front();
                check("sb_out_pc", bus.if_pc, o.pc);
                check("sb_out_instr", bus.if_instr, o.instr);
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic do_reset(input logic drain);
        if (drain) begin
            check("drain_req", 32'(exp_req.size()), 32'd0);
            check("drain_out", 32'(exp_out.size()), 32'd0);
        end
        rst_n = 1'b0;
        pend = 1'b0;
        inject = 1'b0;
        lat = 1;
        exp_req.delete();
        exp_out.delete();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready = 1'b1;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_instr", bus.if_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_out(input logic [31:0] pc);
        out_t o;
        o.pc = pc;
        o.instr = instr_of(pc);
        exp_out.push_back(o);
    endtask

    task automatic wait_out(input logic [31:0] pc);
        logic got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            pre();
            if (bus.if_valid) begin
                check("wait_pc", bus.if_pc, pc);
                got = 1'b1;
            end
            post();
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: if_valid never rose, expected pc %h", pc);
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vt[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.if_ready = 1'b1;
        @(negedge clk);
        do_reset(1'b0);

        // Zero-wait streaming: one instruction every other cycle
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
        push_out(32'h0);
        push_out(32'h4);
        push_out(32'h8);
        for (int i = 0; i < 7; i++) begin
            bus.redirect_valid = vt[i].rv;
            bus.redirect_pc = vt[i].rpc;
            bus.if_ready = vt[i].rdy;
            pre();
            check($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vt[i].e_rqv));
            if (vt[i].e_rqv) check($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vt[i].e_addr);
            check($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(vt[i].e_ifv));
            if (vt[i].e_ifv) check($sformatf("vec%0d_if_pc", i), bus.if_pc, vt[i].e_pc);
            post();
        end
        do_reset(1'b1);

        // Decode stalls for 5 cycles holding the first instruction
        exp_req.push_back(32'h0);
        push_out(32'h0);
        cyc();
        cyc();
        bus.if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pre();
            check("hold_if_valid", 32'(bus.if_valid), 32'd1);
            check("hold_if_pc", bus.if_pc, 32'h0);
            check("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
            post();
        end
        bus.if_ready = 1'b1;
        exp_req.push_back(32'h4);
        pre();
        check("hold_release_req", 32'(bus.imem_req_valid), 32'd1);
        post();
        do_reset(1'b1);

        // Redirect in WAIT, response arrives later and must be dropped
        lat = 3;
        exp_req.push_back(32'h0);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        pre();
        check("rdw_req_valid", 32'(bus.imem_req_valid), 32'd0);
        post();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pre();
            check("rdw_drop_req", 32'(bus.imem_req_valid), 32'd0);
            check("rdw_drop_ifv", 32'(bus.if_valid), 32'd0);
            post();
        end
        exp_req.push_back(32'h100);
        pre();
        check("rdw_new_req", bus.imem_req_addr, 32'h100);
        check("rdw_if_valid", 32'(bus.if_valid), 32'd0);
        post();
        bus.imem_req_ready = 1'b0;
        push_out(32'h100);
        wait_out(32'h100);
        do_reset(1'b1);

        // Redirect coincident with the response
        exp_req.push_back(32'h0);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        pre();
        check("rsr_req_valid", 32'(bus.imem_req_valid), 32'd0);
        post();
        bus.redirect_valid = 1'b0;
        exp_req.push_back(32'h200);
        pre();
        check("rsr_if_valid", 32'(bus.if_valid), 32'd0);
        check("rsr_req_valid2", 32'(bus.imem_req_valid), 32'd1);
        check("rsr_req_addr", bus.imem_req_addr, 32'h200);
        post();
        bus.imem_req_ready = 1'b0;
        push_out(32'h200);
        wait_out(32'h200);
        do_reset(1'b1);

        // Redirect flushes a held, unconsumed instruction
        exp_req.push_back(32'h0);
        cyc();
        cyc();
        bus.if_ready = 1'b0;
        pre();
        check("rfl_if_valid", 32'(bus.if_valid), 32'd1);
        check("rfl_req_valid", 32'(bus.imem_req_valid), 32'd0);
        post();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.if_ready = 1'b1;
        exp_req.push_back(32'h40);
        pre();
        check("rfl_if_valid2", 32'(bus.if_valid), 32'd0);
        check("rfl_req_addr", bus.imem_req_addr, 32'h40);
        post();
        bus.imem_req_ready = 1'b0;
        push_out(32'h40);
        wait_out(32'h40);
        do_reset(1'b1);

        // Wrap at the top of the address space, then async reset while in WAIT
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        pre();
        check("wrp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        post();
        bus.redirect_valid = 1'b0;
        exp_req.push_back(32'hFFFF_FFFC);
        pre();
        check("wrp_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        post();
        cyc();
        exp_req.push_back(32'h0);
        push_out(32'hFFFF_FFFC);
        pre();
        check("wrp_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check("wrp_next_addr", bus.imem_req_addr, 32'h0);
        post();
        do_reset(1'b1);
        inject = 1'b1;
        exp_req.push_back(32'h0);
        push_out(32'h0);
        pre();
        check("rst_restart_req", 32'(bus.imem_req_valid), 32'd1);
        post();
        bus.imem_req_ready = 1'b0;
        wait_out(32'h0);
        do_reset(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
